if_else_seg_pipe: RTL and testbench

- Parametrised, pipelined successor of the single-segment if/else combine block used in the modulation-unroll datapath.
- Processes LANES independent segments per beat. Each lane computes an "if" branch value and an "else" branch value from its two array operands, then selects one with a per-lane or global condition taken from input_bit.
- Adds valid/ready flow control, a fixed 2-cycle pipeline with full-throughput backpressure, and a selectable condition mode.
- Sits between the array-reference generators and the segment combiner/packer.

---
 rtl/if_else_seg_pipe_pkg.sv | 16 +
 rtl/if_else_lane_calc.sv | 23 ++
 rtl/if_else_seg_pipe.sv | 103 ++++++++++
 tb/tb_if_else_seg_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_else_seg_pipe_pkg.sv
// Shared definitions for the if/else segment pipeline: condition-mode
// encoding and the lane slicing helper used to unpack lane operands.
package if_else_seg_pipe_pkg;

  // Condition source selection, sampled together with each beat.
  typedef enum logic {
    COND_PER_LANE = 1'b0,
    COND_GLOBAL   = 1'b1
  } cond_mode_e;

  // Low bit index of lane `lane` inside a packed bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/if_else_lane_calc.sv
// Single-lane combine: forms the if-branch (a+b) and else-branch (a-b)
// values and selects one with the lane condition. Purely combinational.
module if_else_lane_calc #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] result
);

  logic [W-1:0] if_val;
  logic [W-1:0] else_val;

  // Both branch values wrap modulo 2^W; carry/borrow are dropped on purpose.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    if_val   = a + b;
    else_val = a - b;
    result   = c ? if_val : else_val;
  end

endmodule

// File: rtl/if_else_seg_pipe.sv
// Two-stage valid/ready pipeline that processes LANES if/else segments per
// beat. S1 captures the beat; S2 holds the selected per-lane result.
module if_else_seg_pipe
  import if_else_seg_pipe_pkg::*;
#(
  parameter int W      = 32,
  parameter int LANES  = 4,
  parameter int COND_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COND_W-1:0]   input_bit,
  input  logic                cond_mode,
  input  logic [LANES*W-1:0]  array_ref_wire,
  input  logic [LANES*W-1:0]  array_ref_m_wire,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*W-1:0]  segment_combine,
  output logic [LANES-1:0]    cond_taken
);

  // Stage 1: raw beat as accepted.
  logic               s1_valid;
  logic [LANES*W-1:0] s1_a;
  logic [LANES*W-1:0] s1_b;
  logic [COND_W-1:0]  s1_input_bit;
  logic               s1_mode;

  // Stage 2: selected results, drives the outputs directly.
  logic               s2_valid;
  logic [LANES*W-1:0] s2_data;
  logic [LANES-1:0]   s2_taken;

  logic               s2_load;
  logic [LANES-1:0]   s1_cond;
  logic [LANES*W-1:0] s1_result;

  // S2 takes a new beat when empty or when its beat leaves this cycle;
  // S1 moves forward under exactly the same condition.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    in_ready = !s1_valid || s2_load;
  end

  // Per-lane condition from the captured condition word and mode.
  always_comb begin
    s1_cond = '0;
    if (cond_mode_e'(s1_mode) == COND_GLOBAL) begin
      s1_cond = {LANES{|s1_input_bit}};
    end else begin
      s1_cond = s1_input_bit[LANES-1:0];
    end
  end

  // One combine unit per lane between S1 and S2.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if_else_lane_calc #(.W(W)) u_calc (
      .a      (s1_a[lane_lo(i, W) +: W]),
      .b      (s1_b[lane_lo(i, W) +: W]),
      .c      (s1_cond[i]),
      .result (s1_result[lane_lo(i, W) +: W])
    );
  end

  // Pipeline registers with synchronous reset; reset drops in-flight beats.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all stages update from pre-edge values.
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_input_bit <= '0;
      s1_mode      <= 1'b0;
      s2_valid     <= 1'b0;
      s2_data      <= '0;
      s2_taken     <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data  <= s1_result;
          s2_taken <= s1_cond;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a         <= array_ref_wire;
          s1_b         <= array_ref_m_wire;
          s1_input_bit <= input_bit;
          s1_mode      <= cond_mode;
        end
      end
    end
  end

  assign out_valid       = s2_valid;
  assign segment_combine = s2_data;
  assign cond_taken      = s2_taken;

endmodule

// File: tb/tb_if_else_seg_pipe.sv
// Self-checking bench for if_else_seg_pipe: directed vector table with
// latency checks, reset/backpressure sequences, and a scoreboard that
// checks every output beat against a reference model.
module tb_if_else_seg_pipe;

  localparam int W      = 32;
  localparam int LANES  = 4;
  localparam int COND_W = 32;
  localparam int DW     = LANES * W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [COND_W-1:0] input_bit;
  logic              cond_mode;
  logic [DW-1:0]     array_ref_wire;
  logic [DW-1:0]     array_ref_m_wire;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     segment_combine;
  logic [LANES-1:0]  cond_taken;

  if_else_seg_pipe #(.W(W), .LANES(LANES), .COND_W(COND_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .input_bit        (input_bit),
    .cond_mode        (cond_mode),
    .array_ref_wire   (array_ref_wire),
    .array_ref_m_wire (array_ref_m_wire),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .segment_combine  (segment_combine),
    .cond_taken       (cond_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic [LANES-1:0] taken;
  } exp_t;

  typedef struct {
    logic [COND_W-1:0] ib;
    logic              mode;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic [DW-1:0]     exp_data;
    logic [LANES-1:0]  exp_taken;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference of one beat.
  function automatic exp_t model(input logic [COND_W-1:0] ib, input logic mode,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t r;
    logic c;
    logic [W-1:0] av, bv;
    r.data  = '0;
    r.taken = '0;
    for (int i = 0; i < LANES; i++) begin
      c  = mode ? (ib != '0) : ib[i];
      av = a[i*W +: W];
      bv = b[i*W +: W];
      r.taken[i]       = c;
      r.data[i*W +: W] = c ? av + bv : av - bv;
    end
    return r;
  endfunction

  // Scoreboard: record accepted beats and compare every emitted beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (sb_q.size() == 0) begin
            check("sb_output_without_beat", DW'(sb_q.size()), DW'(1));
          end else begin
            e = sb_q.pop_front();
            check("sb_data", segment_combine, e.data);
            check("sb_taken", DW'(cond_taken), DW'(e.taken));
          end
        end
        if (in_valid && in_ready) begin
          n_in++;
          sb_q.push_back(model(input_bit, cond_mode, array_ref_wire, array_ref_m_wire));
        end
      end
    end
  end

  // Present one beat and hold it until accepted; enters/returns 1 ns after a posedge.
  task automatic send(input logic [COND_W-1:0] ib, input logic mode,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit took;
    int budget;
    in_valid         = 1'b1;
    input_bit        = ib;
    cond_mode        = mode;
    array_ref_wire   = a;
    array_ref_m_wire = b;
    took   = 1'b0;
    budget = 0;
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      budget++;
      if (!took && budget > 200) begin
        check("send_timeout", DW'(in_ready), DW'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_random();
    logic [DW-1:0] a, b;
    for (int i = 0; i < LANES; i++) begin
      a[i*W +: W] = $urandom;
      b[i*W +: W] = $urandom;
    end
    send($urandom & 32'h0000_001F | (($urandom % 4 == 0) ? 32'h0 : 32'h0), 1'($urandom), a, b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && budget < 500) begin
      cycles(1);
      budget++;
    end
    cycles(3);
    check("drain_empty", DW'(sb_q.size()), DW'(0));
    check("drain_in_eq_out", DW'(n_in), DW'(n_out));
  endtask

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] held;
    int   t0, out0;
    bit   done;

    vecs[0] = '{32'h5, 1'b0, {4{32'd10}}, {4{32'd3}},
                {32'd7, 32'd13, 32'd7, 32'd13}, 4'b0101};
    vecs[1] = '{32'h8000_0000, 1'b1, {4{32'hFFFF_FFFF}}, {4{32'd2}},
                {4{32'h0000_0001}}, 4'b1111};
    vecs[2] = '{32'h0, 1'b1, {4{32'd0}}, {4{32'd1}},
                {4{32'hFFFF_FFFF}}, 4'b0000};
    vecs[3] = '{32'h0, 1'b0, {4{32'd0}}, {4{32'd1}},
                {4{32'hFFFF_FFFF}}, 4'b0000};
    vecs[4] = '{32'h8000_0000, 1'b0, {4{32'd5}}, {4{32'd7}},
                {4{32'hFFFF_FFFE}}, 4'b0000};
    vecs[5] = '{32'hA, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd100}},
                {32'd104, 32'hFFFF_FF9F, 32'd102, 32'hFFFF_FF9D}, 4'b1010};

    reset            = 1'b1;
    in_valid         = 1'b0;
    out_ready        = 1'b1;
    input_bit        = '0;
    cond_mode        = 1'b0;
    array_ref_wire   = '0;
    array_ref_m_wire = '0;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_data", segment_combine, '0);
    check("rst_taken", DW'(cond_taken), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;

    // Directed table: each beat must appear exactly two edges after acceptance.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].ib, vecs[v].mode, vecs[v].a, vecs[v].b);
      @(negedge clk);
      check("vec_valid_early", DW'(out_valid), DW'(0));
      @(negedge clk);
      check("vec_valid", DW'(out_valid), DW'(1));
      check("vec_data", segment_combine, vecs[v].exp_data);
      check("vec_taken", DW'(cond_taken), DW'(vecs[v].exp_taken));
      @(posedge clk); #1;
    end
    drain();

    // Reset with two beats buffered: they must be discarded.
    out_ready = 1'b0;
    send(32'h3, 1'b0, {4{32'd1}}, {4{32'd1}});
    send(32'h1, 1'b1, {4{32'd2}}, {4{32'd1}});
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_data", segment_combine, '0);
    check("midrst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    n_in  = 0;
    n_out = 0;
    cycles(5);
    check("midrst_no_output", DW'(n_out), DW'(0));

    // Backpressure: six back-to-back beats, out_ready low in cycles 3..6.
    fork
      begin
        for (int k = 0; k < 6; k++) send_random();
      end
      begin
        for (int c = 0; c < 10; c++) begin
          out_ready = (c < 3 || c > 6);
          @(negedge clk);
          if (c >= 3 && c <= 6) begin
            check("bp_in_ready_low", DW'(in_ready), DW'(0));
            check("bp_out_valid", DW'(out_valid), DW'(1));
            if (c == 3) held = segment_combine;
            else        check("bp_hold_stable", segment_combine, held);
          end
          @(posedge clk); #1;
        end
      end
    join
    drain();
    check("bp_six_out", DW'(n_out), DW'(6));

    // Throughput: 100 beats, no stalls, one output per cycle.
    out_ready = 1'b1;
    out0 = n_out;
    t0   = $time;
    for (int k = 0; k < 100; k++) send_random();
    check("tp_input_cycles", DW'(($time - t0) / 10), DW'(100));
    cycles(2);
    check("tp_output_count", DW'(n_out - out0), DW'(100));
    drain();

    // Random stalls on both sides.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          cycles($urandom_range(0, 2));
          send_random();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom);
          cycles(1);
        end
      end
    join
    drain();
    check("rand_total_in", DW'(n_in), DW'(1106));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
